bcd_to_binary: RTL and testbench
================================

// Module: bcd_to_binary
// PURPOSE
//  Sequential BCD-to-binary converter: reverse "double dabble" (shift right, subtract 3).
//  Companion of the binary-to-BCD path.
//  Turns packed BCD digits (e.g. from rotary/keypad digit entry) back into a binary value.
//  One conversion per start pulse, one shift per clock, start/busy/done handshake.
// PARAMETERS
//  DIGITS  3   number of BCD digits in bcd_in (4 bits each)
//  BIN_W   10  binary result width; must be >= ceil(log2(10^DIGITS)); also the shift-cycle count
// PORTS
//  clk      in   1          system clock, all state on rising edge
//  reset    in   1          asynchronous, active-high reset
//  start    in   1          request conversion; sampled only in IDLE
//  bcd_in   in   4*DIGITS   packed BCD, digit 0 in [3:0]; sampled on the accepting edge only
//  bin_out  out  BIN_W      converted value; registered, held until the next completion
//  busy     out  1          high from the accepting edge until done is asserted
//  done     out  1          one-cycle pulse: bin_out/error valid
//  error    out  1          invalid digit (>9) in the accepted bcd_in; held like bin_out
// BEHAVIOUR
//  Reset (async): state=IDLE; bin_out=0, busy=0, done=0, error=0; shift reg and counter cleared.
//  States:
//   IDLE : busy=0. On start=1:
//          - load shift reg {bcd_in, BIN_W'b0}; count=0; busy=1.
//          - if any digit of bcd_in >9: set err_pend, go DONE.
//          - otherwise go SHIFT.
//   SHIFT: each edge:
//          - shift the whole {bcd,bin} register right by 1 (bcd LSB enters bin MSB).
//          - then, if count != BIN_W-1, subtract 3 from every BCD nibble now >=8.
//          - count++.
//          - after BIN_W shifts (count==BIN_W-1 edge) go DONE.
//   DONE : on the edge into DONE, bin_out <= bin part (or 0 if err_pend); error <= err_pend.
//          - done=1 for exactly this one cycle; busy=0 in the same cycle; next edge -> IDLE.
//  Latency: start accepted at edge k.
//   - Valid input: done high during the cycle after edge k+BIN_W (BIN_W+1 cycles; 11 for the defaults).
//   - Invalid input: done high during the cycle after edge k+1.
//  Width rules: nibble adjust is 4-bit unsigned; result is the BIN_W LSBs; BCD part is zero at end.
//  start while busy or in DONE: ignored; bcd_in changes after acceptance have no effect.
//  start held high continuously: a new conversion is accepted on the first IDLE edge after DONE.
//  Back-to-back throughput: one result per BIN_W+2 cycles.
//  error and bin_out change only on DONE entry; a new conversion keeps the old values until then.
//  Reset mid-conversion: abort immediately to reset values; no done pulse is generated.
// STRUCTURE
//  Shared package/include bcd_defs:
//   - state encodings ST_IDLE, ST_SHIFT, ST_DONE
//   - BCD_DIGIT_W=4, BCD_MAX_DIGIT=9, ADJ_THRESH=8, ADJ_VAL=3
//  Sub-module bcd_nibble_adjust:
//   - combinational: in[3:0] -> (in>=8 ? in-3 : in)
//   - instantiated DIGITS times via generate
//  Top holds the FSM, counter ($clog2(BIN_W) bits), shift register (4*DIGITS+BIN_W bits),
//  the digit-valid check and the output registers.
// TESTING
//  1 reset then bcd_in=12'h999, start 1 cycle -> busy 1; done pulse 11 cycles later; bin_out=999 (10'h3E7), error=0
//  2 bcd_in=12'h000 -> bin_out=0; bcd_in=12'h255 -> bin_out=255 (10'h0FF); bcd_in=12'h100 -> 10'h064
//  3 bcd_in=12'h1A5 -> done 2 cycles after start; error=1, bin_out=0; next bcd_in=12'h042 -> error=0, bin_out=42
//  4 start held high, bcd_in changed to 12'h777 during SHIFT -> result reflects first value only
//   - the 2nd conversion starts on the first IDLE edge after DONE
//  5 assert reset on 5th SHIFT cycle -> outputs 0 immediately, no done
//   - the following conversion of 12'h512 -> 512
//  6 sweep all 0..999 (BCD from reference model) -> bin_out equals index, error=0, one done per start

Source files
------------

// File: rtl/bcd_to_binary_pkg.sv
// Shared constants for the BCD-to-binary converter: FSM encodings, BCD digit
// limits and the reverse double-dabble adjust values.
package bcd_to_binary_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int ADJ_THRESH    = 8;
  localparam int ADJ_VAL       = 3;

  typedef logic [1:0] state_t;

  // Plain constants rather than an enum so older tools and dumps agree on the encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Request/result bundle for the BCD-to-binary converter: start + packed BCD in,
// binary result with busy/done/error status out.
interface bcd_to_binary_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start,
    output bcd_in,
    input  bin_out,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  start,
    input  bcd_in,
    output bin_out,
    output busy,
    output done,
    output error
  );

endinterface

// File: rtl/bcd_to_binary_nibble_adjust.sv
// One BCD nibble correction step of the reverse double dabble:
// a digit that reached 8 or more after the right shift loses 3.
module bcd_nibble_adjust
  import bcd_to_binary_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= BCD_DIGIT_W'(ADJ_THRESH)) ? din - BCD_DIGIT_W'(ADJ_VAL) : din;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double dabble, one shift per clock)
// with a start/busy/done handshake and invalid-digit detection.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  bcd_to_binary_if.slave   bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_t            state_reg;
  logic [SR_W-1:0]   sr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              err_pend_reg;
  logic [BIN_W-1:0]  bin_out_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              error_reg;

  logic [SR_W-1:0]   sr_shift;
  logic [BCD_W-1:0]  bcd_adj;
  logic [SR_W-1:0]   sr_next;
  logic [DIGITS-1:0] digit_bad;
  logic              any_bad;
  logic              last_shift;
  logic              enter_done;

  assign sr_shift = sr_reg >> 1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_nibble_adjust u_adj (
        .din  (sr_shift[BIN_W + BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
        .dout (bcd_adj[BCD_DIGIT_W*gi +: BCD_DIGIT_W])
      );
      assign digit_bad[gi] = digit_invalid(bus.bcd_in[BCD_DIGIT_W*gi +: BCD_DIGIT_W]);
    end
  endgenerate

  assign any_bad    = |digit_bad;
  assign last_shift = (count_reg == CNT_W'(BIN_W - 1));

  // The final shift carries no adjust: the BCD part is already empty by then.
  assign sr_next    = last_shift ? sr_shift : {bcd_adj, sr_shift[BIN_W-1:0]};

  // A rejected input spends one SHIFT cycle doing nothing so both paths report from DONE.
  assign enter_done = (state_reg == ST_SHIFT) && (err_pend_reg || last_shift);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      sr_reg       <= '0;
      count_reg    <= '0;
      err_pend_reg <= 1'b0;
      bin_out_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            sr_reg       <= {bus.bcd_in, {BIN_W{1'b0}}};
            count_reg    <= '0;
            err_pend_reg <= any_bad;
            busy_reg     <= 1'b1;
            state_reg    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!err_pend_reg) begin
            sr_reg    <= sr_next;
            count_reg <= count_reg + CNT_W'(1);
          end
          if (enter_done) begin
            bin_out_reg <= err_pend_reg ? '0 : sr_next[BIN_W-1:0];
            error_reg   <= err_pend_reg;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= ST_DONE;
          end
        end
        ST_DONE: begin
          err_pend_reg <= 1'b0;
          state_reg    <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.bin_out = bin_out_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.error   = error_reg;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed cases plus randomized BCD words
// compared against an arithmetic digit-weight reference model.
module tb_bcd_to_binary;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int LAT_OK  = BIN_W + 1;
  localparam int LAT_ERR = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   prev_val = 0;
  int   prev_err = 0;

  bcd_to_binary_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int observed, input int expected);
    n_vec++;
    if (observed !== expected) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Value of a packed BCD word by digit weights; any digit above 9 makes it invalid.
  function automatic void ref_model(input logic [11:0] bcd, output int val, output int err);
    int d;
    val = 0;
    err = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((bcd >> (4 * i)) & 12'h00F);
      if (d > 9) err = 1;
      val += d * (10 ** i);
    end
    if (err != 0) val = 0;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Called one negedge after the accepting edge; lat counts negedges from there.
  task automatic wait_done(input bit scramble, output int lat, output bit seen);
    lat  = 1;
    seen = bus.done;
    while (!seen && lat < 40) begin
      if (scramble) bus.bcd_in = 12'($urandom);
      @(negedge clk);
      lat++;
      seen = bus.done;
    end
  endtask

  task automatic check_result(input string tag, input logic [11:0] bcd, input int lat, input bit seen);
    int exp_val, exp_err;
    ref_model(bcd, exp_val, exp_err);
    chk({tag, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      chk({tag, "_latency"}, lat, (exp_err != 0) ? LAT_ERR : LAT_OK);
      chk({tag, "_bin_out"}, int'(bus.bin_out), exp_val);
      chk({tag, "_error"}, int'(bus.error), exp_err);
      chk({tag, "_busy_at_done"}, int'(bus.busy), 0);
    end
    $display("conv %s bcd=%03h bin_out=%0d error=%0d latency=%0d", tag, bcd, bus.bin_out, bus.error, lat);
    prev_val = exp_val;
    prev_err = exp_err;
  endtask

  task automatic convert(input string tag, input logic [11:0] bcd);
    int lat;
    bit seen;
    @(negedge clk);
    bus.bcd_in = bcd;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy"}, int'(bus.busy), 1);
    chk({tag, "_hold_bin"}, int'(bus.bin_out), prev_val);
    chk({tag, "_hold_err"}, int'(bus.error), prev_err);
    wait_done(1'b1, lat, seen);
    check_result(tag, bcd, lat, seen);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(bus.done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  ndone;
    bit  seen;
    logic [11:0] w;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_bin_out", int'(bus.bin_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_error", int'(bus.error), 0);
    reset = 1'b0;

    convert("max", 12'h999);
    convert("zero", 12'h000);
    convert("v255", 12'h255);
    convert("v100", 12'h100);
    convert("bad_digit", 12'h1A5);
    convert("after_bad", 12'h042);

    // start held high across DONE; bcd_in moves during the first conversion
    @(negedge clk);
    bus.bcd_in = 12'h123;
    bus.start  = 1'b1;
    @(negedge clk);
    chk("held_busy", int'(bus.busy), 1);
    bus.bcd_in = 12'h777;
    wait_done(1'b0, lat, seen);
    check_result("held_first", 12'h123, lat, seen);
    @(negedge clk);
    chk("held_idle_gap", int'(bus.busy), 0);
    @(negedge clk);
    chk("held_reaccept", int'(bus.busy), 1);
    bus.start = 1'b0;
    wait_done(1'b0, lat, seen);
    check_result("held_second", 12'h777, lat, seen);
    @(negedge clk);

    // reset during the fifth SHIFT cycle
    convert("pre_reset", 12'h999);
    @(negedge clk);
    bus.bcd_in = 12'h345;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_bin_out", int'(bus.bin_out), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_error", int'(bus.error), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    prev_val = 0;
    prev_err = 0;
    convert("post_reset", 12'h512);

    // random words, digits 0..11 so some carry invalid nibbles
    repeat (150) begin
      w = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
      convert("rand", w);
    end

    for (int n = 0; n < 1000; n++) begin
      convert("sweep", to_bcd(n));
      chk("sweep_index", int'(bus.bin_out), n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
